// File: rtl/wb_mem_pkg.sv
// rtl/wb_mem_pkg.sv - shared types and sizing helpers for the Wishbone memory model
// Request fields are sized for the widest supported bus; narrower instances zero-fill the top.
package wb_mem_pkg;

  localparam int WB_MEM_MAX_DW = 128;
  localparam int WB_MEM_MAX_AW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_mem_state_e;

  typedef struct packed {
    logic                       we;
    logic [WB_MEM_MAX_DW/8-1:0] sel;
    logic [WB_MEM_MAX_AW-1:0]   adr;
    logic [WB_MEM_MAX_DW-1:0]   dat;
  } wb_mem_req_t;

  function automatic int wb_mem_lanes(input int dw);
    return dw / 8;
  endfunction

  function automatic int wb_mem_idx_w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/wb_mem_port_fsm.sv
// rtl/wb_mem_port_fsm.sv - per-port request latch, wait counter and IDLE/WAIT/ACK sequencer
// access_o pulses in the cycle whose closing edge enters ACK; req_o is the request to act on then.
module wb_mem_port_fsm
  import wb_mem_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [DW/8-1:0]   sel_i,
  input  logic [AW-1:0]     adr_i,
  input  logic [DW-1:0]     dat_i,
  output logic              access_o,
  output wb_mem_req_t       req_o
);

  localparam int BL = wb_mem_lanes(DW);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  wb_mem_state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  wb_mem_req_t   req_q, req_d, live;

  always_comb begin
    live              = '0;
    live.we           = we_i;
    live.sel[BL-1:0]  = sel_i;
    live.adr[AW-1:0]  = adr_i;
    live.dat[DW-1:0]  = dat_i;
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    req_o    = req_q;
    access_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          req_d = live;
          // with no wait states the access happens on the sampling edge itself
          req_o = live;
          if (WAIT_STATES == 0) begin
            state_d  = ACK;
            access_o = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!(cyc_i && stb_i)) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d  = ACK;
          access_o = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: rtl/wb_mem_model.sv
// rtl/wb_mem_model.sv - multi-port classic Wishbone slave memory over one shared word array
// Optional macro WB_MEM_ERR_EN: out-of-range word addresses answer with err instead of wrapping.
module wb_mem_model
  import wb_mem_pkg::*;
#(
  parameter int N_PORTS     = 2,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_PORTS-1:0]      wb_cyc_i,
  input  logic [N_PORTS-1:0]      wb_stb_i,
  input  logic [N_PORTS-1:0]      wb_we_i,
  input  logic [N_PORTS*DW/8-1:0] wb_sel_i,
  input  logic [N_PORTS*AW-1:0]   wb_adr_i,
  input  logic [N_PORTS*DW-1:0]   wb_dat_i,
  output logic [N_PORTS*DW-1:0]   wb_dat_o,
  output logic [N_PORTS-1:0]      wb_ack_o,
  output logic [N_PORTS-1:0]      wb_err_o
);

  localparam int BL   = wb_mem_lanes(DW);
  localparam int OFFW = wb_mem_idx_w(BL);
  localparam int IW   = wb_mem_idx_w(DEPTH);

  logic [DW-1:0]         mem_q [DEPTH];
  logic [N_PORTS-1:0]    access;
  wb_mem_req_t           req [N_PORTS];
  logic [N_PORTS-1:0]    oob;
  logic [N_PORTS-1:0]    ack_d, ack_q, err_d, err_q;
  logic [N_PORTS*DW-1:0] dat_d, dat_q;
  logic                  unused_req;

  function automatic logic [IW-1:0] word_idx(input wb_mem_req_t r);
    return r.adr[OFFW +: IW];
  endfunction

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    wb_mem_port_fsm #(
      .DW          (DW),
      .AW          (AW),
      .WAIT_STATES (WAIT_STATES)
    ) u_fsm (
      .clk      (clk),
      .rst      (rst),
      .cyc_i    (wb_cyc_i[p]),
      .stb_i    (wb_stb_i[p]),
      .we_i     (wb_we_i[p]),
      .sel_i    (wb_sel_i[p*BL +: BL]),
      .adr_i    (wb_adr_i[p*AW +: AW]),
      .dat_i    (wb_dat_i[p*DW +: DW]),
      .access_o (access[p]),
      .req_o    (req[p])
    );
  end

`ifdef WB_MEM_ERR_EN
  always_comb begin
    oob = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      oob[p] = (req[p].adr[AW-1:0] >> (OFFW + IW)) != '0;
    end
  end
`else
  assign oob = '0;
`endif

  always_comb begin
    ack_d = '0;
    err_d = '0;
    dat_d = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (access[p]) begin
        ack_d[p] = ~oob[p];
        err_d[p] = oob[p];
        if (!oob[p] && !req[p].we) dat_d[p*DW +: DW] = mem_q[word_idx(req[p])];
      end
    end
  end

  // the upper bits of the wide request type are zero-filled and intentionally ignored
  always_comb begin
    unused_req = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      unused_req = unused_req ^ (^{req[p].sel, req[p].adr, req[p].dat});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= '0;
      err_q <= '0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  end

  // ascending port order: a later nonblocking write to the same byte wins, so the highest port does
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (access[p] && req[p].we && !oob[p]) begin
          for (int b = 0; b < BL; b++) begin
            if (req[p].sel[b]) mem_q[word_idx(req[p])][b*8 +: 8] <= req[p].dat[b*8 +: 8];
          end
        end
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_mem_model.sv
// tb/tb_wb_mem_model.sv - self-checking bench for wb_mem_model at 0, 3 and 2 wait states
module tb_wb_mem_model;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  cyc [3];
  logic [1:0]  stb [3];
  logic [1:0]  we  [3];
  logic [1:0]  ack [3];
  logic [1:0]  err [3];
  logic [7:0]  sel [3];
  logic [63:0] adr [3];
  logic [63:0] wdat [3];
  logic [63:0] rdat [3];

  logic [31:0] refm [3][1024];
  int passed = 0;
  int failed = 0;
  int total  = 0;

  wb_mem_model #(.N_PORTS(2), .DW(32), .AW(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_sel_i(sel[0]), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]),
    .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]));
  wb_mem_model #(.N_PORTS(2), .DW(32), .AW(32), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_sel_i(sel[1]), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]),
    .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]));
  wb_mem_model #(.N_PORTS(2), .DW(32), .AW(32), .DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
    .wb_sel_i(sel[2]), .wb_adr_i(adr[2]), .wb_dat_i(wdat[2]),
    .wb_dat_o(rdat[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 2;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_write(input int d, input logic [31:0] a, input logic [31:0] dt,
                             input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) refm[d][widx(a)][b*8 +: 8] = dt[b*8 +: 8];
  endtask

  task automatic set_port(input int d, input int p, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] dt);
    we[d][p]           = w;
    sel[d][p*4 +: 4]   = s;
    adr[d][p*32 +: 32] = a;
    wdat[d][p*32 +: 32] = dt;
  endtask

  // raise the strobes, wait (bounded) for ack/err, then confirm latency and one-cycle width
  task automatic run(input int d, input logic [1:0] en, input string tag,
                     output logic [31:0] r0, output logic [31:0] r1,
                     output logic [1:0] ak, output logic [1:0] er);
    int n;
    bit got;
    @(posedge clk); #1;
    cyc[d] = en;
    stb[d] = en;
    n = 0; got = 0; ak = '0; er = '0; r0 = '0; r1 = '0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if ((ack[d] | err[d]) != 2'b00) begin
        got = 1;
        ak = ack[d];
        er = err[d];
        r0 = rdat[d][31:0];
        r1 = rdat[d][63:32];
      end
    end
    cyc[d] = '0;
    stb[d] = '0;
    chk({tag, "_latency"}, 64'(n - 1), 64'(ws_of(d) + 1));
    @(negedge clk);
    chk({tag, "_pulse_width"}, {60'd0, ack[d], err[d]}, 64'd0);
  endtask

  task automatic xfer(input int d, input string tag, input logic [1:0] en, input logic [1:0] w,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] v0, input logic [31:0] v1,
                      input logic [3:0] s0, input logic [3:0] s1);
    logic [31:0] e0, e1, r0, r1;
    logic [1:0]  ak, er;
    set_port(d, 0, w[0], s0, a0, v0);
    set_port(d, 1, w[1], s1, a1, v1);
    e0 = refm[d][widx(a0)];
    e1 = refm[d][widx(a1)];
    run(d, en, tag, r0, r1, ak, er);
    chk({tag, "_ack"}, {62'd0, ak}, {62'd0, en});
    if (en[0] && !w[0]) chk({tag, "_rd0"}, {32'd0, r0}, {32'd0, e0});
    if (en[1] && !w[1]) chk({tag, "_rd1"}, {32'd0, r1}, {32'd0, e1});
    if (en[0] && w[0]) apply_write(d, a0, v0, s0);
    if (en[1] && w[1]) apply_write(d, a1, v1, s1);
  endtask

  task automatic abort_xfer(input int d, input bit use_rst, input logic [31:0] a,
                            input logic [31:0] dt, input string tag);
    int hits;
    hits = 0;
    set_port(d, 0, 1'b1, 4'hF, a, dt);
    @(posedge clk); #1;
    cyc[d] = 2'b01;
    stb[d] = 2'b01;
    @(posedge clk); #1;
    cyc[d] = '0;
    stb[d] = '0;
    if (use_rst) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((ack[d] | err[d]) != 2'b00) hits++;
    end
    chk({tag, "_no_ack"}, 64'(hits), 64'd0);
  endtask

  initial begin
    logic [31:0] r0, r1, a0, a1;
    logic [1:0]  ak, er, en, w;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      cyc[d] = '0; stb[d] = '0; we[d] = '0; sel[d] = '0; adr[d] = '0; wdat[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset_outputs_%0d", d), {ack[d], err[d], rdat[d][59:0]}, 64'd0);

    // basic write then read-back, zero wait states
    xfer(0, "t1_wr", 2'b01, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0);
    xfer(0, "t1_rd", 2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    chk("t1_model", {32'd0, refm[0][4]}, 64'hDEADBEEF);

    // three wait states on port 1
    xfer(1, "t2_wr", 2'b10, 2'b10, 32'h0, 32'h20, 32'h0, 32'h5A5A0F0F, 4'h0, 4'hF);
    xfer(1, "t2_rd", 2'b10, 2'b00, 32'h0, 32'h20, 32'h0, 32'h0, 4'h0, 4'hF);

    // same-edge write/write merge
    xfer(0, "t3_clr", 2'b01, 2'b01, 32'h40, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    xfer(0, "t3_ww", 2'b11, 2'b11, 32'h40, 32'h40, 32'h000000AA, 32'h0000BB00, 4'h1, 4'h3);
    xfer(0, "t3_rd", 2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    chk("t3_model", {32'd0, refm[0][16]}, 64'h0000BB00);

    // same-edge read/write: read sees old data
    xfer(0, "t4_init", 2'b01, 2'b01, 32'h50, 32'h0, 32'hCAFEF00D, 32'h0, 4'hF, 4'h0);
    xfer(0, "t4_rw", 2'b11, 2'b10, 32'h50, 32'h50, 32'h0, 32'h12345678, 4'hF, 4'hF);
    xfer(0, "t4_rd", 2'b01, 2'b00, 32'h50, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);

    // aborted transfers: strobe drop, then reset pulse mid-wait
    xfer(2, "t5_init", 2'b01, 2'b01, 32'h60, 32'h0, 32'h11111111, 32'h0, 4'hF, 4'h0);
    abort_xfer(2, 1'b0, 32'h60, 32'h99999999, "t5_drop");
    xfer(2, "t5_rd_a", 2'b01, 2'b00, 32'h60, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    abort_xfer(2, 1'b1, 32'h60, 32'h77777777, "t5_rst");
    xfer(2, "t5_rd_b", 2'b01, 2'b00, 32'h60, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);

    // address beyond DEPTH
    xfer(0, "t6_w0", 2'b01, 2'b01, 32'h0, 32'h0, 32'hA5A50001, 32'h0, 4'hF, 4'h0);
    set_port(0, 0, 1'b0, 4'hF, 32'h1000, 32'h0);
    run(0, 2'b01, "t6_oob", r0, r1, ak, er);
`ifdef WB_MEM_ERR_EN
    chk("t6_ack", {62'd0, ak}, 64'd0);
    chk("t6_err", {62'd0, er}, 64'd1);
    chk("t6_dat", {32'd0, r0}, 64'd0);
`else
    chk("t6_ack", {62'd0, ak}, 64'd1);
    chk("t6_err", {62'd0, er}, 64'd0);
    chk("t6_dat", {32'd0, r0}, 64'hA5A50001);
`endif

    // randomized dual-port traffic over a small window so conflicts are frequent
    for (int d = 0; d < 3; d += 2) begin
      for (int k = 0; k < 16; k++)
        xfer(d, "rnd_init", 2'b01, 2'b01, 32'h400 + 32'(k * 4), 32'h0, $urandom, 32'h0, 4'hF, 4'h0);
      for (int it = 0; it < 40; it++) begin
        en = 2'($urandom_range(1, 3));
        w  = 2'($urandom);
        a0 = 32'h400 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        a1 = 32'h400 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        if (it % 4 == 0) a1 = a0;
        xfer(d, $sformatf("rnd_d%0d_%0d", d, it), en, w, a0, a1, $urandom, $urandom,
             4'($urandom), 4'($urandom));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
